// File: rtl/core_fetch_pc_ctrl_pkg.sv
// core_fetch_pc_ctrl_pkg: shared constants and FSM encoding for the fetch PC controller
package core_fetch_pc_ctrl_pkg;
  localparam int FETCH_ST_WIDTH = 2;
  localparam int PC_INC = 4;
  typedef enum logic [FETCH_ST_WIDTH-1:0] {
    FETCH_ST_RESET = 2'd0,
    FETCH_ST_REQ   = 2'd1,
    FETCH_ST_WAIT  = 2'd2,
    FETCH_ST_HOLD  = 2'd3
  } fetch_st_t;
endpackage

// File: rtl/core_fetch_pc_ctrl.sv
// core_fetch_pc_ctrl: owns the PC, fetches one instruction at a time and hands it to decode
module core_fetch_pc_ctrl
  import core_fetch_pc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  output logic                  misaligned_o
);
  fetch_st_t state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt;
  logic kill, kill_nxt;
  logic redir, mis, consume, load;
  // a misaligned target is reported and otherwise treated as no redirect at all
  assign mis     = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign redir   = redirect_i && !mis;
  assign consume = instr_ready_i && !stall_i;
  assign load    = (state == FETCH_ST_WAIT) && imem_rvalid_i && !kill && !redir;
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= FETCH_ST_RESET;
    else       state <= state_nxt;
  // next-state logic; redirect beats ready in HOLD, squashed data in WAIT returns to REQ
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_ST_RESET: state_nxt = FETCH_ST_REQ;
      FETCH_ST_REQ:   state_nxt = imem_gnt_i ? FETCH_ST_WAIT : FETCH_ST_REQ;
      FETCH_ST_WAIT:  state_nxt = !imem_rvalid_i ? FETCH_ST_WAIT :
                                  (kill || redir) ? FETCH_ST_REQ : FETCH_ST_HOLD;
      FETCH_ST_HOLD:  state_nxt = (redir || consume) ? FETCH_ST_REQ : FETCH_ST_HOLD;
      default:        state_nxt = FETCH_ST_RESET;
    endcase
  end
  // Moore outputs; the request address is always the live PC
  always_comb begin
    imem_req_o    = (state == FETCH_ST_REQ);
    instr_valid_o = (state == FETCH_ST_HOLD);
    imem_addr_o   = pc;
  end
  // next PC and kill flag; kill marks an outstanding response that belongs to a stale PC
  always_comb begin
    pc_nxt   = (redir && state != FETCH_ST_RESET) ? redirect_pc_i :
               (state == FETCH_ST_HOLD && consume) ? pc + DATA_WIDTH'(PC_INC) : pc;
    kill_nxt = (state == FETCH_ST_REQ)  ? (kill || (imem_gnt_i && redir)) :
               (state == FETCH_ST_WAIT) ? (!imem_rvalid_i && (kill || redir)) : kill;
  end
  // PC, kill flag, presented instruction and misaligned pulse
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pc           <= BOOT_ADDR;
      kill         <= 1'b0;
      instr_o      <= '0;
      instr_pc_o   <= '0;
      misaligned_o <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      kill         <= kill_nxt;
      misaligned_o <= mis;
      if (load) begin
        instr_o    <= imem_rdata_i;
        instr_pc_o <= pc;
      end
    end
endmodule

// File: tb/tb_core_fetch_pc_ctrl.sv
// tb_core_fetch_pc_ctrl: directed stimulus with a scoreboard checking every consumed instruction
module tb_core_fetch_pc_ctrl;
  logic clk = 0, rst = 1, rst2 = 1;
  logic stall = 0, redirect = 0, gnt = 0, rvalid = 0, ready = 0;
  logic [31:0] redirect_pc = 0, rdata = 0;
  logic req, valid, mis, req2, valid2, mis2;
  logic [31:0] addr, instr, instr_pc, addr2, instr2, instr_pc2;
  int checks = 0, errors = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  core_fetch_pc_ctrl #(.DATA_WIDTH(32), .BOOT_ADDR(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(ready), .misaligned_o(mis));

  core_fetch_pc_ctrl #(.DATA_WIDTH(32), .BOOT_ADDR(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst2), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .instr_valid_o(valid2), .instr_o(instr2), .instr_pc_o(instr_pc2),
    .instr_ready_i(ready), .misaligned_o(mis2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expects REQ at exp_addr, grants it, returns data next cycle; ends in HOLD
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input bit push);
    chk("req_high", 32'(req), 32'd1);
    chk("req_addr", addr, exp_addr);
    gnt = 1;
    tick();
    gnt = 0;
    rvalid = 1;
    rdata = data;
    if (push) sb.push_back({data, exp_addr});
    tick();
    rvalid = 0;
    chk("valid_after_fetch", 32'(valid), 32'd1);
  endtask

  // monitor: every instruction decode takes must match the next expected one
  always @(negedge clk) begin
    if (!rst && valid && ready && !stall && !redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got %h at pc %h expected none", instr, instr_pc);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_instr", instr, e[63:32]);
        chk("sb_pc", instr_pc, e[31:0]);
      end
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_mis", 32'(mis), 32'd0);
    rst = 0;
    tick();
    // sequential fetch with immediate consumption
    ready = 1;
    fetch(32'h0, 32'h0000_0013, 1);
    tick();
    fetch(32'h4, 32'h0000_0013, 1);
    tick();
    fetch(32'h8, 32'h0000_0013, 1);
    tick();
    // stall holds the presented instruction
    stall = 1;
    fetch(32'hC, 32'h0050_0093, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_pc", instr_pc, 32'hC);
      tick();
    end
    stall = 0;
    tick();
    chk("after_stall_addr", addr, 32'h10);
    // redirect while waiting for data
    gnt = 1;
    tick();
    gnt = 0;
    redirect = 1;
    redirect_pc = 32'h100;
    tick();
    redirect = 0;
    rvalid = 1;
    rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 0;
    chk("wait_redir_valid", 32'(valid), 32'd0);
    chk("wait_redir_addr", addr, 32'h100);
    fetch(32'h100, 32'h0000_0033, 1);
    tick();
    // redirect coincident with grant
    gnt = 1;
    redirect = 1;
    redirect_pc = 32'h40;
    tick();
    gnt = 0;
    redirect = 0;
    chk("gnt_redir_req", 32'(req), 32'd0);
    rvalid = 1;
    rdata = 32'h0000_0BAD;
    tick();
    rvalid = 0;
    chk("gnt_redir_valid", 32'(valid), 32'd0);
    fetch(32'h40, 32'h00A0_0113, 1);
    tick();
    // misaligned redirect in HOLD is ignored but flagged
    ready = 0;
    fetch(32'h44, 32'h0010_8093, 1);
    redirect = 1;
    redirect_pc = 32'h102;
    tick();
    redirect = 0;
    chk("mis_pulse", 32'(mis), 32'd1);
    chk("mis_valid", 32'(valid), 32'd1);
    chk("mis_pc", instr_pc, 32'h44);
    tick();
    chk("mis_clear", 32'(mis), 32'd0);
    chk("mis_still_valid", 32'(valid), 32'd1);
    ready = 1;
    tick();
    chk("mis_next_addr", addr, 32'h48);
    // aligned redirect beats ready in HOLD
    ready = 0;
    fetch(32'h48, 32'h0000_0073, 0);
    redirect = 1;
    redirect_pc = 32'h200;
    ready = 1;
    tick();
    redirect = 0;
    chk("hold_redir_valid", 32'(valid), 32'd0);
    chk("hold_redir_addr", addr, 32'h200);
    // reset asserted in WAIT, then a stray rvalid
    gnt = 1;
    tick();
    gnt = 0;
    rst = 1;
    #1;
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_addr", addr, 32'h0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_pc", instr_pc, 32'h0);
    tick();
    rst = 0;
    rvalid = 1;
    rdata = 32'h1234_5678;
    tick();
    rvalid = 0;
    chk("stray_req", 32'(req), 32'd1);
    chk("stray_addr", addr, 32'h0);
    tick();
    chk("stray_valid", 32'(valid), 32'd0);
    // PC wrap-around on the second instance
    rst = 1;
    ready = 1;
    rst2 = 0;
    tick();
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    chk("wrap_first_req", 32'(req2), 32'd1);
    gnt = 1;
    tick();
    gnt = 0;
    rvalid = 1;
    rdata = 32'h0000_0013;
    tick();
    rvalid = 0;
    chk("wrap_valid", 32'(valid2), 32'd1);
    chk("wrap_instr_pc", instr_pc2, 32'hFFFF_FFFC);
    tick();
    chk("wrap_second_addr", addr2, 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
